// File: rtl/rx_shift.sv
// Byte-to-block deserializer: gathers 16 UART bytes into a 128-bit block and
// hands it to a downstream FIFO, flagging lost blocks and timed-out partials.
module rx_shift #(
    parameter logic [31:0] TIMEOUT = 32'd0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   rx_data,
    input  logic         rx_done,
    input  logic         buffer_full,
    input  logic         clr_err,
    output logic         buffer_write,
    output logic [127:0] dout,
    output logic         busy,
    output logic         overrun,
    output logic         frame_err
);

    // Only the first 15 bytes need storage; the 16th goes straight from
    // rx_data into the holding register alongside them.
    logic [119:0] sr_q, sr_d;
    logic [3:0]   ctr_q, ctr_d;
    logic [127:0] dout_q, dout_d;
    logic         pending_q, pending_d;
    logic [31:0]  idle_q, idle_d;
    logic         overrun_q, overrun_d;
    logic         frame_err_q, frame_err_d;

    logic block_done;
    logic timeout_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q        <= '0;
            ctr_q       <= '0;
            dout_q      <= '0;
            pending_q   <= 1'b0;
            idle_q      <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            ctr_q       <= ctr_d;
            dout_q      <= dout_d;
            pending_q   <= pending_d;
            idle_q      <= idle_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        buffer_write = pending_q & ~buffer_full;
        block_done   = rx_done && (ctr_q == 4'd15);
        // A byte arriving in the firing cycle wins over the timeout.
        timeout_hit  = (TIMEOUT != 32'd0) && (ctr_q != 4'd0) && !rx_done
                       && (idle_q == TIMEOUT - 32'd1);

        sr_d        = sr_q;
        ctr_d       = ctr_q;
        dout_d      = dout_q;
        pending_d   = pending_q;
        idle_d      = idle_q;
        overrun_d   = overrun_q & ~clr_err;
        frame_err_d = frame_err_q & ~clr_err;

        if (rx_done) begin
            idle_d = '0;
            if (block_done) begin
                ctr_d = 4'd0;
            end else begin
                sr_d  = {sr_q[111:0], rx_data};
                ctr_d = ctr_q + 4'd1;
            end
        end else if (timeout_hit) begin
            ctr_d       = 4'd0;
            idle_d      = '0;
            frame_err_d = 1'b1;
        end else if (ctr_q != 4'd0) begin
            idle_d = idle_q + 32'd1;
        end else begin
            idle_d = '0;
        end

        // A completed block may replace the held one only if that one is
        // leaving this cycle; otherwise the newcomer is dropped.
        if (block_done) begin
            if (!pending_q || !buffer_full) begin
                dout_d    = {sr_q, rx_data};
                pending_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (buffer_write) begin
            pending_d = 1'b0;
        end
    end

    assign dout      = dout_q;
    assign busy      = (ctr_q != 4'd0);
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_rx_shift.sv
// Self-checking bench for rx_shift: directed scenarios plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_rx_shift;

    localparam logic [31:0] TO = 32'd8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_done = 1'b0;
    logic         buffer_full = 1'b0;
    logic         clr_err = 1'b0;
    logic         buffer_write;
    logic [127:0] dout;
    logic         busy;
    logic         overrun;
    logic         frame_err;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]   coll[$];
    logic [127:0] m_held;
    bit           m_valid;
    int unsigned  m_idle;
    bit           m_ov;
    bit           m_fe;
    logic [127:0] wr_q[$];

    rx_shift #(.TIMEOUT(TO)) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .buffer_full(buffer_full),
        .clr_err(clr_err),
        .buffer_write(buffer_write),
        .dout(dout),
        .busy(busy),
        .overrun(overrun),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] pack_coll();
        logic [127:0] blk;
        blk = '0;
        for (int k = 0; k < 16; k++) blk[127-8*k -: 8] = coll[k];
        return blk;
    endfunction

    function automatic void model_clear();
        coll.delete();
        m_held  = '0;
        m_valid = 1'b0;
        m_idle  = 0;
        m_ov    = 1'b0;
        m_fe    = 1'b0;
    endfunction

    // Effect of one rising edge on the model: byte arrival, block hand-off,
    // timeout discard and sticky flags.
    function automatic void model_step(input bit d, input logic [7:0] b, input bit f, input bit c);
        bit bw;
        bit ov_set;
        bit fe_set;
        bit done_blk;
        bw = m_valid && !f;
        ov_set = 1'b0;
        fe_set = 1'b0;
        done_blk = 1'b0;
        if (d) begin
            coll.push_back(b);
            m_idle = 0;
            if (coll.size() == 16) begin
                done_blk = 1'b1;
                if (!m_valid || bw) begin
                    m_held  = pack_coll();
                    m_valid = 1'b1;
                end else begin
                    ov_set = 1'b1;
                end
                coll.delete();
            end
        end else if (coll.size() != 0) begin
            if (m_idle == TO - 1) begin
                coll.delete();
                fe_set = 1'b1;
                m_idle = 0;
            end else begin
                m_idle++;
            end
        end
        if (!done_blk && bw) m_valid = 1'b0;
        m_ov = ov_set || (m_ov && !c);
        m_fe = fe_set || (m_fe && !c);
    endfunction

    task automatic cycle(input bit d, input logic [7:0] b, input bit f, input bit c);
        logic exp_bw;
        @(negedge clk);
        rx_done     = d;
        rx_data     = d ? b : 8'($urandom);
        buffer_full = f;
        clr_err     = c;
        #1;
        exp_bw = m_valid && !f;
        if (buffer_write !== exp_bw) begin
            miscompares++;
            $display("[TB] FAIL buffer_write: got %b expected %b", buffer_write, exp_bw);
        end
        vectors++;
        if (dout !== m_held) begin
            miscompares++;
            $display("[TB] FAIL dout: got %h expected %h", dout, m_held);
        end
        vectors++;
        if (busy !== (coll.size() != 0)) begin
            miscompares++;
            $display("[TB] FAIL busy: got %b expected %b", busy, coll.size() != 0);
        end
        vectors++;
        if (overrun !== m_ov) begin
            miscompares++;
            $display("[TB] FAIL overrun: got %b expected %b", overrun, m_ov);
        end
        vectors++;
        if (frame_err !== m_fe) begin
            miscompares++;
            $display("[TB] FAIL frame_err: got %b expected %b", frame_err, m_fe);
        end
        vectors++;
        if (buffer_write === 1'b1) wr_q.push_back(dout);
        @(posedge clk);
        model_step(d, b, f, c);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rx_done = 1'b0;
        clr_err = 1'b0;
        reset   = 1'b1;
        #1;
        buffer_full = 1'b0;
        #1;
        if ({buffer_write, dout, busy, overrun, frame_err} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_async: got bw=%b dout=%h busy=%b ov=%b fe=%b expected all 0",
                     buffer_write, dout, busy, overrun, frame_err);
        end
        vectors++;
        @(negedge clk);
        #1;
        if ({buffer_write, dout, busy, overrun, frame_err} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_held: got bw=%b dout=%h busy=%b ov=%b fe=%b expected all 0",
                     buffer_write, dout, busy, overrun, frame_err);
        end
        vectors++;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        #1;
        if ({buffer_write, dout, busy, overrun, frame_err} !== '0) begin
            miscompares++;
            $display("[TB] FAIL power_on_reset: got bw=%b dout=%h busy=%b expected all 0",
                     buffer_write, dout, busy);
        end
        vectors++;
        pulse_reset();
    endtask

    task automatic test_basic_block();
        logic [127:0] exp_blk;
        exp_blk = 128'h000102030405060708090A0B0C0D0E0F;
        wr_q.delete();
        for (int k = 0; k < 16; k++) cycle(1'b1, 8'(k), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        if (wr_q.size() != 1 || wr_q[0] !== exp_blk) begin
            miscompares++;
            $display("[TB] FAIL basic_block: got %0d writes first=%h expected 1 write of %h",
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 128'h0, exp_blk);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_busy: got %b expected 0", busy);
        end
        vectors++;
    endtask

    task automatic test_backpressure();
        logic [7:0]   b[16];
        logic [127:0] exp_blk;
        wr_q.delete();
        for (int k = 0; k < 16; k++) begin
            b[k] = 8'($urandom);
            exp_blk[127-8*k -: 8] = b[k];
        end
        for (int k = 0; k < 16; k++) cycle(1'b1, b[k], 1'b1, 1'b0);
        for (int k = 0; k < 40; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        #2;
        if (wr_q.size() != 0 || dout !== exp_blk) begin
            miscompares++;
            $display("[TB] FAIL backpressure_hold: got %0d writes dout=%h expected 0 writes dout=%h",
                     wr_q.size(), dout, exp_blk);
        end
        vectors++;
        for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        if (wr_q.size() != 1 || wr_q[0] !== exp_blk) begin
            miscompares++;
            $display("[TB] FAIL backpressure_release: got %0d writes expected 1 write of %h",
                     wr_q.size(), exp_blk);
        end
        vectors++;
    endtask

    task automatic test_overrun();
        logic [127:0] blk11;
        blk11 = {16{8'h11}};
        wr_q.delete();
        for (int k = 0; k < 16; k++) cycle(1'b1, 8'h11, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) cycle(1'b1, 8'h22, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        #2;
        if (overrun !== 1'b1 || dout !== blk11) begin
            miscompares++;
            $display("[TB] FAIL overrun_set: got ov=%b dout=%h expected ov=1 dout=%h",
                     overrun, dout, blk11);
        end
        vectors++;
        for (int k = 0; k < 4; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        if (wr_q.size() != 1 || wr_q[0] !== blk11) begin
            miscompares++;
            $display("[TB] FAIL overrun_write: got %0d writes expected exactly 1 of %h",
                     wr_q.size(), blk11);
        end
        vectors++;
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        #2;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL overrun_clear: got %b expected 0", overrun);
        end
        vectors++;
    endtask

    task automatic test_timeout();
        logic [7:0]   b[16];
        logic [127:0] exp_blk;
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        wr_q.delete();
        for (int k = 0; k < 5; k++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        if (frame_err !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL timeout_early: got fe=%b busy=%b expected fe=0 busy=1", frame_err, busy);
        end
        vectors++;
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        if (frame_err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timeout_fire: got fe=%b busy=%b expected fe=1 busy=0", frame_err, busy);
        end
        vectors++;
        for (int k = 0; k < 16; k++) begin
            b[k] = 8'($urandom);
            exp_blk[127-8*k -: 8] = b[k];
        end
        for (int k = 0; k < 16; k++) cycle(1'b1, b[k], 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        if (wr_q.size() != 1 || wr_q[0] !== exp_blk) begin
            miscompares++;
            $display("[TB] FAIL timeout_recover: got %0d writes expected 1 write of %h",
                     wr_q.size(), exp_blk);
        end
        vectors++;
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [7:0]   b[16];
        logic [127:0] exp_blk;
        wr_q.delete();
        for (int k = 0; k < 9; k++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        pulse_reset();
        for (int k = 0; k < 16; k++) cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        pulse_reset();
        if (wr_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL reset_no_write: got %0d writes expected 0", wr_q.size());
        end
        vectors++;
        for (int k = 0; k < 16; k++) begin
            b[k] = 8'($urandom);
            exp_blk[127-8*k -: 8] = b[k];
        end
        for (int k = 0; k < 16; k++) cycle(1'b1, b[k], 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        if (wr_q.size() != 1 || wr_q[0] !== exp_blk) begin
            miscompares++;
            $display("[TB] FAIL reset_recover: got %0d writes expected 1 write of %h",
                     wr_q.size(), exp_blk);
        end
        vectors++;
    endtask

    task automatic test_back_to_back();
        logic [7:0]   a[16];
        logic [7:0]   b[16];
        logic [127:0] exp_a;
        logic [127:0] exp_b;
        wr_q.delete();
        for (int k = 0; k < 16; k++) begin
            a[k] = 8'($urandom);
            b[k] = 8'($urandom);
            exp_a[127-8*k -: 8] = a[k];
            exp_b[127-8*k -: 8] = b[k];
        end
        for (int k = 0; k < 16; k++) cycle(1'b1, a[k], 1'b1, 1'b0);
        for (int k = 0; k < 15; k++) cycle(1'b1, b[k], 1'b1, 1'b0);
        cycle(1'b1, b[15], 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        if (wr_q.size() != 2 || wr_q[0] !== exp_a || wr_q[1] !== exp_b) begin
            miscompares++;
            $display("[TB] FAIL back_to_back: got %0d writes expected %h then %h",
                     wr_q.size(), exp_a, exp_b);
        end
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL back_to_back_overrun: got %b expected 0", overrun);
        end
        vectors++;
    endtask

    // Bursty random traffic; occasional long gaps exercise the timeout path.
    task automatic test_random();
        bit full;
        full = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0) full = !full;
            if ($urandom_range(0, 40) == 0) begin
                for (int g = 0; g < 9; g++) cycle(1'b0, 8'h00, full, 1'b0);
            end else begin
                cycle($urandom_range(0, 3) != 0, 8'($urandom), full,
                      $urandom_range(0, 30) == 0);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic_block();
        test_backpressure();
        test_overrun();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rx_shift.md
RX_SHIFT -- requirements
Module: rx_shift

Interface
REQ-001 Parameter TIMEOUT, default 0 (32-bit): inter-byte idle cycles before a partial block is discarded; 0 disables the timeout.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rx_data  input  8  received byte from the UART receiver; valid only when rx_done=1.
REQ-005 rx_done  input  1  one-cycle pulse per received byte.
REQ-006 buffer_full  input  1  downstream block FIFO cannot accept a write this cycle.
REQ-007 clr_err  input  1  synchronous clear of the sticky overrun and frame_err flags.
REQ-008 buffer_write  output  1  FIFO write strobe; FIFO samples dout when buffer_write=1.
REQ-009 dout  output  128  assembled block, first received byte in [127:120].
REQ-010 busy  output  1  partial block in progress (byte count != 0).
REQ-011 overrun  output  1  sticky: a completed block was lost.
REQ-012 frame_err  output  1  sticky: a partial block was discarded by timeout.

Function
REQ-013 Internal state SHALL be: shift register sr[127:0], byte counter ctr[3:0], holding register dout, pending flag, idle counter.
REQ-014 On rx_done=1 with ctr<15, sr SHALL load {sr[119:0], rx_data} and ctr SHALL increment by one.
REQ-015 On rx_done=1 with ctr=15 (block complete), {sr[119:0], rx_data} SHALL go directly to dout, ctr SHALL wrap to 0, and pending SHALL be set to 1 on the next edge.
REQ-016 Byte order SHALL match tx_shift: byte k (0-based, arrival order) lands in dout[127-8k -: 8].
REQ-017 buffer_write SHALL be combinational: pending & ~buffer_full; dout SHALL be held stable while pending=1.
REQ-018 pending SHALL clear on the edge where buffer_write=1, unless a new block completes on the same edge, in which case dout loads the new block and pending stays 1.
REQ-019 Latency: rx_done of the 16th byte at edge N -> dout valid and buffer_write=1 (if not full) in the cycle after N.
REQ-020 While pending=1 and buffer_full=1, byte collection into sr SHALL continue unaffected.
REQ-021 If a block completes while pending=1 and buffer_full=1, dout SHALL keep the older block, the new block SHALL be dropped, and overrun SHALL be set to 1.
REQ-022 Idle counter SHALL reset to 0 on every rx_done and increment each cycle while ctr!=0 and rx_done=0.
REQ-023 If TIMEOUT!=0 and the idle counter reaches TIMEOUT-1 with ctr!=0, the next edge SHALL:
 - set ctr to 0;
 - set frame_err to 1;
 - leave sr contents don't-care.
REQ-024 If rx_done arrives in the same cycle the timeout fires, the byte SHALL win: it is accepted and no timeout occurs.
REQ-025 clr_err=1 SHALL clear overrun and frame_err; a set event in the same cycle SHALL take priority (flag ends at 1).
REQ-026 busy SHALL equal (ctr != 0).

Reset
REQ-027 While reset=1, regardless of clk, the block SHALL hold all of the following: sr=0, ctr=0, dout=0, pending=0, idle counter=0, buffer_write=0, busy=0, overrun=0, frame_err=0.
REQ-028 Reset asserted mid-block or with a pending block SHALL discard all collected data without issuing buffer_write.
REQ-029 The first rx_done after reset deassertion SHALL be treated as byte 0 of a new block.

Verification
REQ-030 Setup: 16 rx_done pulses carrying bytes 0x00..0x0F, buffer_full=0. Required response: one buffer_write pulse, dout=0x000102030405060708090A0B0C0D0E0F, busy=0 afterwards.
REQ-031 Setup: buffer_full=1 for 40 cycles after a block completes. Required response: buffer_write=0 and dout stable throughout; a single write one cycle after buffer_full falls.
REQ-032 Setup: two blocks (0x11 repeated, then 0x22 repeated) complete while buffer_full=1. Required response: overrun=1 and dout=0x11 repeated; after buffer_full falls, exactly one write of 0x11; clr_err then clears overrun.
REQ-033 Setup: TIMEOUT=8, 5 bytes sent, then silence. Required response: frame_err=1 after 8 idle cycles, busy=0; the next 16 bytes produce one correct block.
REQ-034 Setup: reset pulsed after byte 9 and again while pending=1. Required response: no buffer_write, all outputs 0; a following 16-byte block is written correctly.
REQ-035 Setup: block completion coincides with a buffer_write of the previous block. Required response: both blocks written in order, overrun=0.
